// File: rtl/alu_seq_exec.sv
// alu_seq_exec: sequential ALU execute stage with valid/ready handshakes on both sides.
// Latency: 1 cycle accept->valid_o for non-shift ops and shamt==0; 1+shamt cycles for iterative shifts.
// Backpressure: ready_o is high only in IDLE; the result is held in DONE until ready_i.
//
// Ports:
//   clk, reset        rising-edge clock, synchronous active-high reset
//   valid_i/ready_o   request handshake (ALU_Operation_i, A_i, B_i sampled on accept)
//   valid_o/ready_i   result handshake (ALU_Result_o, Zero_o registered and held)
//
// Build option: define ALU_FAST_SHIFT_EN to replace the one-bit-per-cycle shifter
// with a combinational barrel shifter; the SHIFT state and counter then disappear.
module alu_seq_exec #(
    parameter int DATA_WIDTH  = 32,
    parameter int SHAMT_WIDTH = 5
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  valid_i,
    output logic                  ready_o,
    input  logic [3:0]            ALU_Operation_i,
    input  logic [DATA_WIDTH-1:0] A_i,
    input  logic [DATA_WIDTH-1:0] B_i,
    output logic                  valid_o,
    input  logic                  ready_i,
    output logic [DATA_WIDTH-1:0] ALU_Result_o,
    output logic                  Zero_o
);

    localparam logic [3:0] OP_ADD  = 4'b0000;
    localparam logic [3:0] OP_SUB  = 4'b0001;
    localparam logic [3:0] OP_AND  = 4'b0010;
    localparam logic [3:0] OP_OR   = 4'b0011;
    localparam logic [3:0] OP_XOR  = 4'b0100;
    localparam logic [3:0] OP_SLL  = 4'b0101;
    localparam logic [3:0] OP_SRL  = 4'b0110;
    localparam logic [3:0] OP_SRA  = 4'b0111;
    localparam logic [3:0] OP_SLT  = 4'b1000;
    localparam logic [3:0] OP_SLTU = 4'b1001;
    localparam logic [3:0] OP_LUI  = 4'b1010;

`ifdef ALU_FAST_SHIFT_EN
    typedef enum logic [1:0] {ST_IDLE, ST_DONE} state_t;
`else
    typedef enum logic [1:0] {ST_IDLE, ST_SHIFT, ST_DONE} state_t;
`endif

    state_t                  state_q, state_d;
    logic                    ready_q, ready_d;
    logic                    valid_q, valid_d;
    logic [DATA_WIDTH-1:0]   result_q, result_d;
    logic                    zero_q, zero_d;
`ifndef ALU_FAST_SHIFT_EN
    logic [3:0]              op_q, op_d;
    logic [DATA_WIDTH-1:0]   work_q, work_d;
    logic [SHAMT_WIDTH-1:0]  cnt_q, cnt_d;
`endif

    logic [SHAMT_WIDTH-1:0]  shamt_in;
    logic                    is_shift_in;

    assign shamt_in    = B_i[SHAMT_WIDTH-1:0];
    assign is_shift_in = (ALU_Operation_i == OP_SLL) || (ALU_Operation_i == OP_SRL) ||
                         (ALU_Operation_i == OP_SRA);

    // Single-cycle result. In the iterative build this is only reached for
    // shifts with shamt==0, so shift ops simply pass A through.
    function automatic logic [DATA_WIDTH-1:0] alu_calc(
        input logic [3:0]             op,
        input logic [DATA_WIDTH-1:0]  a,
        input logic [DATA_WIDTH-1:0]  b,
        input logic [SHAMT_WIDTH-1:0] sh
    );
        logic [DATA_WIDTH-1:0] r;
        r = '0;
        case (op)
            OP_ADD:  r = a + b;
            OP_SUB:  r = a - b;
            OP_AND:  r = a & b;
            OP_OR:   r = a | b;
            OP_XOR:  r = a ^ b;
`ifdef ALU_FAST_SHIFT_EN
            OP_SLL:  r = a << sh;
            OP_SRL:  r = a >> sh;
            OP_SRA:  r = $unsigned($signed(a) >>> sh);
`else
            OP_SLL, OP_SRL, OP_SRA: r = a;
`endif
            OP_SLT:  r = {{(DATA_WIDTH-1){1'b0}}, ($signed(a) < $signed(b))};
            OP_SLTU: r = {{(DATA_WIDTH-1){1'b0}}, (a < b)};
            OP_LUI:  r = b;
            default: r = '0;
        endcase
`ifndef ALU_FAST_SHIFT_EN
        r = r | (sh & '0);  // shamt only matters to the barrel variant
`endif
        return r;
    endfunction

`ifndef ALU_FAST_SHIFT_EN
    // One bit of shift per cycle in the direction chosen by the latched opcode.
    function automatic logic [DATA_WIDTH-1:0] shift_one(
        input logic [3:0]            op,
        input logic [DATA_WIDTH-1:0] w
    );
        logic [DATA_WIDTH-1:0] r;
        case (op)
            OP_SLL:  r = {w[DATA_WIDTH-2:0], 1'b0};
            OP_SRL:  r = {1'b0, w[DATA_WIDTH-1:1]};
            OP_SRA:  r = {w[DATA_WIDTH-1], w[DATA_WIDTH-1:1]};
            default: r = w;
        endcase
        return r;
    endfunction
`endif

    always_comb begin
        state_d  = state_q;
        result_d = result_q;
        zero_d   = zero_q;
`ifndef ALU_FAST_SHIFT_EN
        op_d     = op_q;
        work_d   = work_q;
        cnt_d    = cnt_q;
`endif
        case (state_q)
            ST_IDLE: begin
                if (valid_i) begin
`ifndef ALU_FAST_SHIFT_EN
                    if (is_shift_in && (shamt_in != '0)) begin
                        op_d    = ALU_Operation_i;
                        work_d  = A_i;
                        cnt_d   = shamt_in;
                        state_d = ST_SHIFT;
                    end else
`endif
                    begin
                        result_d = alu_calc(ALU_Operation_i, A_i, B_i, shamt_in);
                        zero_d   = (result_d == '0);
                        state_d  = ST_DONE;
                    end
                end
            end
`ifndef ALU_FAST_SHIFT_EN
            ST_SHIFT: begin
                work_d = shift_one(op_q, work_q);
                cnt_d  = cnt_q - SHAMT_WIDTH'(1);
                // The shift performed while the counter reads 1 is the last one.
                if (cnt_q == SHAMT_WIDTH'(1)) begin
                    result_d = work_d;
                    zero_d   = (work_d == '0);
                    state_d  = ST_DONE;
                end
            end
`endif
            ST_DONE: begin
                if (ready_i) begin
                    state_d = ST_IDLE;
                end
            end
            default: state_d = ST_IDLE;
        endcase
        // Handshake outputs are registered copies of the next state.
        ready_d = (state_d == ST_IDLE);
        valid_d = (state_d == ST_DONE);
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q  <= ST_IDLE;
            ready_q  <= 1'b1;
            valid_q  <= 1'b0;
            result_q <= '0;
            zero_q   <= 1'b0;
`ifndef ALU_FAST_SHIFT_EN
            op_q     <= '0;
            work_q   <= '0;
            cnt_q    <= '0;
`endif
        end else begin
            state_q  <= state_d;
            ready_q  <= ready_d;
            valid_q  <= valid_d;
            result_q <= result_d;
            zero_q   <= zero_d;
`ifndef ALU_FAST_SHIFT_EN
            op_q     <= op_d;
            work_q   <= work_d;
            cnt_q    <= cnt_d;
`endif
        end
    end

    assign ready_o      = ready_q;
    assign valid_o      = valid_q;
    assign ALU_Result_o = result_q;
    assign Zero_o       = zero_q;

endmodule

// File: tb/tb_alu_seq_exec.sv
module tb_alu_seq_exec;

    logic        clk;
    logic        reset;
    logic        valid_i;
    logic        ready_o;
    logic [3:0]  ALU_Operation_i;
    logic [31:0] A_i;
    logic [31:0] B_i;
    logic        valid_o;
    logic        ready_i;
    logic [31:0] ALU_Result_o;
    logic        Zero_o;

    int total = 0;
    int bad   = 0;

    alu_seq_exec #(.DATA_WIDTH(32), .SHAMT_WIDTH(5)) dut (
        .clk             (clk),
        .reset           (reset),
        .valid_i         (valid_i),
        .ready_o         (ready_o),
        .ALU_Operation_i (ALU_Operation_i),
        .A_i             (A_i),
        .B_i             (B_i),
        .valid_o         (valid_o),
        .ready_i         (ready_i),
        .ALU_Result_o    (ALU_Result_o),
        .Zero_o          (Zero_o)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

`ifdef ALU_FAST_SHIFT_EN
    localparam bit FAST = 1'b1;
`else
    localparam bit FAST = 1'b0;
`endif

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=0x%08h expected=0x%08h", tag, obs, exp);
        end
    endtask

    // Issue one request, wait (bounded) for valid_o, check result/zero/latency.
    // ready_o must stay low from accept until the result is presented.
    task automatic run_op(input string tag, input logic [3:0] op, input logic [31:0] a,
                          input logic [31:0] b, input logic [31:0] exp_res,
                          input logic exp_zero, input int exp_lat);
        int   lat;
        logic rdy_seen;
        check({tag, "_ready_before"}, {31'd0, ready_o}, 32'd1);
        valid_i = 1'b1;
        ALU_Operation_i = op;
        A_i = a;
        B_i = b;
        tick();
        valid_i = 1'b0;
        A_i = 32'hDEAD_BEEF;
        B_i = 32'hDEAD_BEEF;
        lat = 1;
        rdy_seen = ready_o;
        while (!valid_o && lat < 200) begin
            tick();
            lat++;
            rdy_seen = rdy_seen | ready_o;
        end
        check({tag, "_latency"}, lat, exp_lat);
        check({tag, "_result"}, ALU_Result_o, exp_res);
        check({tag, "_zero"}, {31'd0, Zero_o}, {31'd0, exp_zero});
        check({tag, "_ready_busy"}, {31'd0, rdy_seen}, 32'd0);
    endtask

    task automatic handoff(input string tag);
        ready_i = 1'b1;
        tick();
        ready_i = 1'b0;
        check({tag, "_valid_after"}, {31'd0, valid_o}, 32'd0);
        check({tag, "_ready_after"}, {31'd0, ready_o}, 32'd1);
    endtask

    initial begin
        reset = 1'b1;
        valid_i = 1'b0;
        ready_i = 1'b0;
        ALU_Operation_i = 4'h0;
        A_i = '0;
        B_i = '0;
        tick();
        tick();
        check("rst_ready",  {31'd0, ready_o}, 32'd1);
        check("rst_valid",  {31'd0, valid_o}, 32'd0);
        check("rst_result", ALU_Result_o, 32'd0);
        check("rst_zero",   {31'd0, Zero_o}, 32'd0);
        reset = 1'b0;
        tick();

        // Arithmetic and logic, one cycle each
        run_op("add_wrap", 4'b0000, 32'hFFFF_FFFF, 32'h1, 32'h0, 1'b1, 1);
        handoff("add_wrap");
        run_op("sub", 4'b0001, 32'd5, 32'd7, 32'hFFFF_FFFE, 1'b0, 1);
        handoff("sub");
        run_op("slt", 4'b1000, 32'hFFFF_FFFE, 32'h1, 32'h1, 1'b0, 1);
        handoff("slt");
        run_op("sltu", 4'b1001, 32'hFFFF_FFFE, 32'h1, 32'h0, 1'b1, 1);
        handoff("sltu");
        run_op("and", 4'b0010, 32'h0000_F0F0, 32'h0000_0FF0, 32'h0000_00F0, 1'b0, 1);
        handoff("and");
        run_op("or", 4'b0011, 32'h0000_F000, 32'h0000_000F, 32'h0000_F00F, 1'b0, 1);
        handoff("or");
        run_op("xor", 4'b0100, 32'hFF00_FF00, 32'hFFFF_FFFF, 32'h00FF_00FF, 1'b0, 1);
        handoff("xor");
        run_op("lui", 4'b1010, 32'h1111_1111, 32'hABCD_0000, 32'hABCD_0000, 1'b0, 1);
        handoff("lui");

        // Shifts: upper bits of B must be ignored
        run_op("sra4", 4'b0111, 32'h8000_0000, 32'h24, 32'hF800_0000, 1'b0, FAST ? 1 : 5);
        handoff("sra4");
        run_op("sll3", 4'b0101, 32'h11, 32'hFFFF_FFE3, 32'h88, 1'b0, FAST ? 1 : 4);
        handoff("sll3");
        run_op("srl31", 4'b0110, 32'h8000_0000, 32'h1F, 32'h1, 1'b0, FAST ? 1 : 32);
        handoff("srl31");

        // shamt==0 completes in one cycle; hold the result under backpressure
        // and pulse a request that must be ignored
        run_op("sll0", 4'b0101, 32'h1, 32'h0, 32'h1, 1'b0, 1);
        for (int i = 0; i < 3; i++) begin
            valid_i = (i == 1);
            ALU_Operation_i = 4'b0000;
            A_i = 32'd7;
            B_i = 32'd7;
            tick();
            check($sformatf("hold%0d_valid", i), {31'd0, valid_o}, 32'd1);
            check($sformatf("hold%0d_result", i), ALU_Result_o, 32'h1);
            check($sformatf("hold%0d_ready", i), {31'd0, ready_o}, 32'd0);
        end
        valid_i = 1'b0;
        handoff("sll0");

        // Reset in the middle of a long shift aborts it
        check("abort_ready_before", {31'd0, ready_o}, 32'd1);
        valid_i = 1'b1;
        ALU_Operation_i = 4'b0110;
        A_i = 32'hFFFF_FFFF;
        B_i = 32'd31;
        tick();
        valid_i = 1'b0;
        for (int i = 0; i < 9; i++) tick();
        check("abort_valid_pre", {31'd0, valid_o}, FAST ? 32'd1 : 32'd0);
        reset = 1'b1;
        tick();
        reset = 1'b0;
        check("abort_ready",  {31'd0, ready_o}, 32'd1);
        check("abort_valid",  {31'd0, valid_o}, 32'd0);
        check("abort_result", ALU_Result_o, 32'd0);
        check("abort_zero",   {31'd0, Zero_o}, 32'd0);
        run_op("add_post", 4'b0000, 32'd2, 32'd3, 32'd5, 1'b0, 1);
        handoff("add_post");

        // Undefined opcode
        run_op("undef", 4'b1111, 32'h1234, 32'h5678, 32'h0, 1'b1, 1);
        handoff("undef");

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
